// File: rtl/prog_ram_loader_pkg.sv
// Shared constants for the TD4 program-RAM loader: widths, frame marker and FSM encoding.
package prog_ram_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int WORDS  = 16;

  localparam logic [DATA_W-1:0] SOF_BYTE  = 8'hA5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_CSUM   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;

  function automatic logic is_loading(input logic [2:0] st);
    return (st == ST_DATA) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_ram_loader_if.sv
// Host byte stream into the loader. A byte transfers on a rising clock edge where
// valid && ready; the host keeps data/valid stable while ready is low.
interface prog_ram_loader_if;

  logic [prog_ram_loader_pkg::DATA_W-1:0] data;
  logic                                   valid;
  logic                                   ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/prog_ram_loader_ram.sv
// WORDS x DATA_W program store: async clear, synchronous write, combinational read.
module prog_ram_loader_ram
  import prog_ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_ram_loader.sv
// Frame loader for the TD4 program store: SOF, WORDS data bytes, 8-bit additive checksum.
// The core is released from reset only after a frame whose checksum matches.
module prog_ram_loader
  import prog_ram_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_reset,
  prog_ram_loader_if.slave        host,
  input  logic [ADDR_W-1:0]       address,
  output logic [DATA_W-1:0]       out,
  output logic                    cpu_n_reset,
  output logic                    load_busy,
  output logic                    load_err,
  output logic [2:0]              state_dbg
);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic              xfer;
  logic              we;

  assign host.ready = (state != ST_COMMIT);
  assign xfer       = host.valid && host.ready;
  assign we         = (state == ST_DATA) && xfer;
  assign load_busy  = is_loading(state);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN: if (xfer && host.data == SOF_BYTE) state_nxt = ST_DATA;
      ST_DATA:         if (xfer && addr == LAST_ADDR)     state_nxt = ST_CSUM;
      ST_CSUM:         if (xfer) state_nxt = (host.data == sum) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT:       state_nxt = ST_RUN;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // cpu_n_reset is registered from the next state so it tracks RUN without glitches.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      sum         <= '0;
      load_err    <= 1'b0;
      cpu_n_reset <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu_n_reset <= (state_nxt == ST_RUN);
      if (state_nxt == ST_DATA && state != ST_DATA) begin
        addr     <= '0;
        sum      <= '0;
        load_err <= 1'b0;
      end
      if (we) begin
        addr <= addr + 1'b1;
        sum  <= sum + host.data;
      end
      if (state == ST_CSUM && xfer && host.data != sum) load_err <= 1'b1;
    end
  end

  prog_ram_loader_ram u_ram (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (we),
    .waddr   (addr),
    .wdata   (host.data),
    .raddr   (address),
    .rdata   (out)
  );

endmodule
